// File: rtl/asu_pkg.sv
// rtl/asu_pkg.sv - mode and FSM state encodings for the add/sub/shift unit
package asu_pkg;

  typedef enum logic [1:0] {
    ASU_ADD = 2'b00,
    ASU_SUB = 2'b01,
    ASU_SLL = 2'b10,
    ASU_SRL = 2'b11
  } asu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } asu_state_e;

endpackage

// File: rtl/asu_addsub.sv
// rtl/asu_addsub.sv - combinational adder/subtractor with carry or borrow out
module asu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout_or_borrow
);

  logic [WIDTH:0] res;

  // Zero-extending both operands puts the borrow of a - b in the top bit.
  always_comb begin
    res = '0;
    if (sub) res = {1'b0, a} - {1'b0, b};
    else     res = {1'b0, a} + {1'b0, b};
  end

  assign sum            = res[WIDTH-1:0];
  assign cout_or_borrow = res[WIDTH];

endmodule

// File: rtl/asu_seq.sv
// rtl/asu_seq.sv - sequential add/sub/shift unit; shifts take one cycle per bit
module asu_seq
  import asu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             busy
);

  asu_state_e       state;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             out_valid_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] sh_q;
  logic             dir_q;

  logic [WIDTH-1:0] as_sum;
  logic             as_cob;
  logic [WIDTH-1:0] sh_next;
  logic             sh_bit;
  logic [SHW-1:0]   amt;

  assign amt = y[SHW-1:0];

  asu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a              (x),
    .b              (y),
    .sub            (mode == ASU_SUB),
    .sum            (as_sum),
    .cout_or_borrow (as_cob)
  );

  // dir_q = 1 shifts right; sh_bit is the bit leaving the register this step.
  always_comb begin
    sh_next = '0;
    sh_bit  = 1'b0;
    if (dir_q) begin
      sh_next = {1'b0, sh_q[WIDTH-1:1]};
      sh_bit  = sh_q[0];
    end else begin
      sh_next = {sh_q[WIDTH-2:0], 1'b0};
      sh_bit  = sh_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      cnt         <= '0;
      sh_q        <= '0;
      dir_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            case (mode)
              ASU_ADD, ASU_SUB: begin
                out_q       <= as_sum;
                carry_q     <= as_cob;
                out_valid_q <= 1'b1;
                state       <= ST_DONE;
              end
              default: begin
                dir_q <= (mode == ASU_SRL);
                if (amt == '0) begin
                  out_q       <= x;
                  carry_q     <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= ST_DONE;
                end else begin
                  sh_q  <= x;
                  cnt   <= amt;
                  state <= ST_SHIFT;
                end
              end
            endcase
          end
        end
        ST_SHIFT: begin
          sh_q <= sh_next;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            out_q       <= sh_next;
            carry_q     <= sh_bit;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_asu_seq.sv
// tb/tb_asu_seq.sv - directed vector bench for asu_seq at WIDTH 8 and 16
module tb_asu_seq;
  import asu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, ordy8, c8, b8;
  logic [1:0] m8;
  logic [7:0] x8, y8, o8;

  logic        iv16, ir16, ov16, ordy16, c16, b16;
  logic [1:0]  m16;
  logic [15:0] x16, y16, o16;

  asu_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .mode      (m8),
    .x         (x8),
    .y         (y8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out       (o8),
    .carry     (c8),
    .busy      (b8)
  );

  asu_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .mode      (m16),
    .x         (x16),
    .y         (y16),
    .out_valid (ov16),
    .out_ready (ordy16),
    .out       (o16),
    .carry     (c16),
    .busy      (b16)
  );

  // sel picks which instance the helper tasks drive and observe.
  bit          sel;
  logic [15:0] g_out;
  logic        g_c, g_ov, g_ir, g_busy;
  assign g_out  = sel ? o16 : {8'h00, o8};
  assign g_c    = sel ? c16 : c8;
  assign g_ov   = sel ? ov16 : ov8;
  assign g_ir   = sel ? ir16 : ir8;
  assign g_busy = sel ? b16 : b8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wide;
    logic [1:0]  mode;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] exp_out;
    logic        exp_c;
    int          done_edge;  // rising edge after the accept edge that enters DONE
    string       name;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] m, input logic [15:0] xv, input logic [15:0] yv);
    if (sel) begin
      iv16 = v; m16 = m; x16 = xv; y16 = yv;
    end else begin
      iv8 = v; m8 = m; x8 = xv[7:0]; y8 = yv[7:0];
    end
  endtask

  task automatic set_ordy(input bit r);
    if (sel) ordy16 = r;
    else     ordy8  = r;
  endtask

  task automatic do_op(input string name, input logic [1:0] m, input logic [15:0] xv,
                       input logic [15:0] yv, input logic [15:0] exp_out, input logic exp_c,
                       input int done_edge);
    int k;
    bit ir_bad;
    chk({name, "_ready_before"}, g_ir, 1);
    drive(1'b1, m, xv, yv);
    @(posedge clk); #1;
    drive(1'b0, m ^ 2'b11, ~xv, ~yv);
    k = 0;
    ir_bad = 1'b0;
    while (!g_ov && k < 40) begin
      if (g_ir) ir_bad = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_done_edge"}, k, done_edge);
    chk({name, "_ready_low"}, ir_bad, 0);
    chk({name, "_out"}, g_out, exp_out);
    chk({name, "_carry"}, g_c, exp_c);
    set_ordy(1'b1);
    @(posedge clk); #1;
    set_ordy(1'b0);
    chk({name, "_valid_cleared"}, g_ov, 0);
    chk({name, "_ready_after"}, g_ir, 1);
    chk({name, "_out_retained"}, g_out, exp_out);
    chk({name, "_carry_retained"}, g_c, exp_c);
  endtask

  initial begin
    vecs[0]  = '{0, ASU_ADD, 16'h00F0, 16'h0020, 16'h0010, 1'b1, 0,  "add8_f0_20"};
    vecs[1]  = '{0, ASU_SUB, 16'h0005, 16'h0007, 16'h00FE, 1'b1, 0,  "sub8_05_07"};
    vecs[2]  = '{0, ASU_SUB, 16'h0007, 16'h0005, 16'h0002, 1'b0, 0,  "sub8_07_05"};
    vecs[3]  = '{0, ASU_SLL, 16'h0081, 16'h0003, 16'h0008, 1'b0, 3,  "sll8_81_3"};
    vecs[4]  = '{0, ASU_SRL, 16'h0081, 16'h0001, 16'h0040, 1'b1, 1,  "srl8_81_1"};
    vecs[5]  = '{0, ASU_SRL, 16'h0081, 16'h0008, 16'h0081, 1'b0, 0,  "srl8_81_amt0"};
    vecs[6]  = '{0, ASU_ADD, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 0,  "add8_ff_01"};
    vecs[7]  = '{0, ASU_SLL, 16'h00C0, 16'h0002, 16'h0000, 1'b1, 2,  "sll8_c0_2"};
    vecs[8]  = '{0, ASU_SRL, 16'h0003, 16'h00F1, 16'h0001, 1'b1, 1,  "srl8_03_upper"};
    vecs[9]  = '{0, ASU_SUB, 16'h005A, 16'h005A, 16'h0000, 1'b0, 0,  "sub8_equal"};
    vecs[10] = '{1, ASU_ADD, 16'hF000, 16'h2000, 16'h1000, 1'b1, 0,  "add16_f000"};
    vecs[11] = '{1, ASU_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 0,  "sub16_05_07"};
    vecs[12] = '{1, ASU_SUB, 16'h1234, 16'h0034, 16'h1200, 1'b0, 0,  "sub16_1234"};
    vecs[13] = '{1, ASU_SLL, 16'h8001, 16'h0013, 16'h0008, 1'b0, 3,  "sll16_8001_3"};
    vecs[14] = '{1, ASU_SRL, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1,  "srl16_8001_1"};
    vecs[15] = '{1, ASU_SRL, 16'h8001, 16'h0010, 16'h8001, 1'b0, 0,  "srl16_amt0"};
    vecs[16] = '{1, ASU_SLL, 16'h0003, 16'h000F, 16'h8000, 1'b1, 15, "sll16_0003_15"};

    rst_n = 1'b0;
    sel = 1'b0;
    iv8 = 0; ordy8 = 0; m8 = 0; x8 = 0; y8 = 0;
    iv16 = 0; ordy16 = 0; m16 = 0; x16 = 0; y16 = 0;
    #12;
    chk("rst_out8", o8, 0);
    chk("rst_carry8", c8, 0);
    chk("rst_valid8", ov8, 0);
    chk("rst_busy8", b8, 0);
    chk("rst_ready8", ir8, 1);
    chk("rst_out16", o16, 0);
    chk("rst_valid16", ov16, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      sel = vecs[i].wide;
      do_op(vecs[i].name, vecs[i].mode, vecs[i].x, vecs[i].y,
            vecs[i].exp_out, vecs[i].exp_c, vecs[i].done_edge);
    end

    // Stall in DONE while a new request is pending; it must not be taken.
    sel = 1'b0;
    drive(1'b1, ASU_ADD, 16'h0001, 16'h0002);
    @(posedge clk); #1;
    drive(1'b1, ASU_SUB, 16'h00FF, 16'h00FF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_out", g_out, 16'h0003);
      chk("hold_valid", g_ov, 1);
      chk("hold_ready", g_ir, 0);
    end
    drive(1'b0, ASU_ADD, 16'h0000, 16'h0000);
    set_ordy(1'b1);
    @(posedge clk); #1;
    set_ordy(1'b0);
    chk("hold_release_valid", g_ov, 0);
    chk("hold_release_ready", g_ir, 1);
    @(posedge clk); #1;
    chk("hold_no_queue_valid", g_ov, 0);
    chk("hold_no_queue_busy", g_busy, 0);
    chk("hold_no_queue_out", g_out, 16'h0003);

    // Asynchronous reset in the middle of a 7-step shift.
    drive(1'b1, ASU_SLL, 16'h0081, 16'h0007);
    @(posedge clk); #1;
    drive(1'b0, ASU_ADD, 16'h0000, 16'h0000);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("midshift_busy", g_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midshift_rst_out", g_out, 0);
    chk("midshift_rst_carry", g_c, 0);
    chk("midshift_rst_valid", g_ov, 0);
    chk("midshift_rst_busy", g_busy, 0);
    chk("midshift_rst_ready", g_ir, 1);
    @(posedge clk); #1;
    chk("midshift_rst_valid_held", g_ov, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst_add", ASU_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
